// File: rtl/mem_access_unit.sv
// mem_access_unit: MIPS32 memory-stage load/store unit.
// Runs one req/ack transaction on the data-memory port for each load or store
// in MEM. It also formats the load result and stalls the pipeline until the
// access completes.
//
// Parameters:
//   TIMEOUT        max BUSY cycles without dmem_ack before the access is aborted (>=1)
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   mem_read_m     load in MEM
//   mem_write_m    store in MEM (wins if both set)
//   mem_size_m     00 byte, 01 half, 10/11 word
//   mem_unsigned_m zero-extend loads when set
//   alu_out_m      effective byte address
//   write_data_m   right-justified store data
//   dmem_*         data-memory request port (registered, latched at issue)
//   read_data_m    registered formatted load result
//   stall_m        combinational pipeline freeze
//   addr_err_m     combinational misalignment flag
//   bus_err_m      registered one-cycle abort pulse
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_m,
  input  logic        mem_write_m,
  input  logic [1:0]  mem_size_m,
  input  logic        mem_unsigned_m,
  input  logic [31:0] alu_out_m,
  input  logic [31:0] write_data_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] read_data_m,
  output logic        stall_m,
  output logic        addr_err_m,
  output logic        bus_err_m
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            bus_err_q, bus_err_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // Load-format context, latched at issue since EX/MEM inputs are ignored afterwards.
  logic [1:0]      lo_q, lo_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;

  logic            op;
  logic            misaligned;
  logic            issue;
  logic [3:0]      be_issue;
  logic [31:0]     wdata_issue;

  function automatic logic [31:0] fmt_load(logic [31:0] rd, logic [1:0] lo, logic [1:0] sz,
                                           logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(rd >> {lo, 3'b000});
    h = lo[1] ? rd[31:16] : rd[15:0];
    case (sz)
      2'b00:   r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  assign op         = mem_read_m | mem_write_m;
  assign misaligned = op & (((mem_size_m == 2'b01) & alu_out_m[0]) |
                            (mem_size_m[1] & (alu_out_m[1:0] != 2'b00)));
  assign issue      = (state_q == StIdle) & op & ~misaligned;

  always_comb begin
    be_issue    = 4'b1111;
    wdata_issue = write_data_m;
    case (mem_size_m)
      2'b00: begin
        be_issue    = 4'b0001 << alu_out_m[1:0];
        wdata_issue = {4{write_data_m[7:0]}};
      end
      2'b01: begin
        be_issue    = alu_out_m[1] ? 4'b1100 : 4'b0011;
        wdata_issue = {2{write_data_m[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    bus_err_d = 1'b0;
    cnt_d     = cnt_q;
    lo_d      = lo_q;
    size_d    = size_q;
    uns_d     = uns_q;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          state_d = StBusy;
          req_d   = 1'b1;
          we_d    = mem_write_m;
          addr_d  = {alu_out_m[31:2], 2'b00};
          be_d    = be_issue;
          wdata_d = wdata_issue;
          cnt_d   = '0;
          lo_d    = alu_out_m[1:0];
          size_d  = mem_size_m;
          uns_d   = mem_unsigned_m;
        end
      end
      StBusy: begin
        // Ack in the final timeout cycle is checked first, so it completes cleanly.
        if (dmem_ack) begin
          state_d = StDone;
          req_d   = 1'b0;
          if (!we_q) rdata_d = fmt_load(dmem_rdata, lo_q, size_q, uns_q);
        end else if (cnt_q == CntLast) begin
          state_d   = StDone;
          req_d     = 1'b0;
          bus_err_d = 1'b1;
          if (!we_q) rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
      cnt_q     <= '0;
      lo_q      <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
      cnt_q     <= cnt_d;
      lo_q      <= lo_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
    end
  end

  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_be     = be_q;
  assign dmem_wdata  = wdata_q;
  assign read_data_m = rdata_q;
  assign bus_err_m   = bus_err_q;
  assign stall_m     = issue | (state_q == StBusy);
  assign addr_err_m  = misaligned;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read_m = 1'b0;
  logic        mem_write_m = 1'b0;
  logic [1:0]  mem_size_m = 2'b00;
  logic        mem_unsigned_m = 1'b0;
  logic [31:0] alu_out_m = '0;
  logic [31:0] write_data_m = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic [31:0] read_data_m;
  logic        stall_m;
  logic        addr_err_m;
  logic        bus_err_m;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_read_m     (mem_read_m),
    .mem_write_m    (mem_write_m),
    .mem_size_m     (mem_size_m),
    .mem_unsigned_m (mem_unsigned_m),
    .alu_out_m      (alu_out_m),
    .write_data_m   (write_data_m),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_be        (dmem_be),
    .dmem_wdata     (dmem_wdata),
    .dmem_rdata     (dmem_rdata),
    .dmem_ack       (dmem_ack),
    .read_data_m    (read_data_m),
    .stall_m        (stall_m),
    .addr_err_m     (addr_err_m),
    .bus_err_m      (bus_err_m)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one op from IDLE, acks in cycle ack_at (0 = never), returns what the port showed.
  task automatic run_op(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                        input int ack_at, output int req_cycles, output int done_cyc,
                        output logic we, output logic [3:0] be, output logic [31:0] a,
                        output logic [31:0] wdat, output logic berr);
    bit done;
    mem_write_m    = wr;
    mem_read_m     = ~wr;
    mem_size_m     = sz;
    mem_unsigned_m = uns;
    alu_out_m      = addr;
    write_data_m   = wd;
    #1;
    check_eq("stall_cycle0", 32'(stall_m), 32'd1);
    req_cycles = 0;
    done_cyc   = -1;
    we = 1'b0; be = '0; a = '0; wdat = '0; berr = 1'b0;
    done = 1'b0;
    for (int k = 1; k <= 8 && !done; k++) begin
      step();
      dmem_ack = 1'b0;
      if (dmem_req) begin
        req_cycles++;
        if (k == 1) begin
          we = dmem_we; be = dmem_be; a = dmem_addr; wdat = dmem_wdata;
        end
      end
      if (!stall_m) begin
        done_cyc = k;
        berr     = bus_err_m;
        done     = 1'b1;
      end else if (k == ack_at) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rd;
      end
    end
    if (!done) check_eq("access_bound", 32'd0, 32'd1);
    mem_read_m  = 1'b0;
    mem_write_m = 1'b0;
    dmem_ack    = 1'b0;
    step();
  endtask

  int          rc, dc;
  logic        we;
  logic [3:0]  be;
  logic [31:0] a, wdat;
  logic        berr;

  initial begin
    #12;
    check_eq("rst_req", 32'(dmem_req), 32'd0);
    check_eq("rst_addr", dmem_addr, 32'd0);
    check_eq("rst_be", 32'(dmem_be), 32'd0);
    check_eq("rst_rdm", read_data_m, 32'd0);
    check_eq("rst_stall", 32'(stall_m), 32'd0);
    check_eq("rst_berr", 32'(bus_err_m), 32'd0);
    rst_n = 1'b1;
    step();

    // SW, ack in cycle 2
    run_op(1'b1, 2'b10, 1'b0, 32'h104, 32'hDEADBEEF, 32'h0, 2, rc, dc, we, be, a, wdat, berr);
    check_eq("sw_req_cycles", 32'(rc), 32'd2);
    check_eq("sw_done_cyc", 32'(dc), 32'd3);
    check_eq("sw_we", 32'(we), 32'd1);
    check_eq("sw_be", 32'(be), 32'hF);
    check_eq("sw_addr", a, 32'h104);
    check_eq("sw_wdata", wdat, 32'hDEADBEEF);
    check_eq("sw_berr", 32'(berr), 32'd0);
    check_eq("sw_rdm_hold", read_data_m, 32'd0);

    // LB signed / LBU / LH signed
    run_op(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 32'h80FF_0000, 1, rc, dc, we, be, a, wdat, berr);
    check_eq("lb_done_cyc", 32'(dc), 32'd2);
    check_eq("lb_we", 32'(we), 32'd0);
    check_eq("lb_addr", a, 32'h200);
    check_eq("lb_be", 32'(be), 32'b1000);
    check_eq("lb_rdm", read_data_m, 32'hFFFF_FF80);
    run_op(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 32'h80FF_0000, 1, rc, dc, we, be, a, wdat, berr);
    check_eq("lbu_rdm", read_data_m, 32'h0000_0080);
    run_op(1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 32'h80FF_0000, 1, rc, dc, we, be, a, wdat, berr);
    check_eq("lh_rdm", read_data_m, 32'hFFFF_80FF);

    // SB / SH lane replication
    run_op(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB, 32'h0, 1, rc, dc, we, be, a, wdat, berr);
    check_eq("sb_be", 32'(be), 32'b0010);
    check_eq("sb_wdata", wdat, 32'hABABABAB);
    check_eq("sb_addr", a, 32'h10);
    check_eq("sb_rdm_hold", read_data_m, 32'hFFFF_80FF);
    run_op(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_1234, 32'h0, 1, rc, dc, we, be, a, wdat, berr);
    check_eq("sh_be", 32'(be), 32'b1100);
    check_eq("sh_wdata", wdat, 32'h12341234);

    // Misaligned LW: no request
    mem_read_m = 1'b1;
    mem_size_m = 2'b10;
    alu_out_m  = 32'h102;
    #1;
    check_eq("mis_addr_err", 32'(addr_err_m), 32'd1);
    check_eq("mis_stall", 32'(stall_m), 32'd0);
    rc = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (dmem_req) rc++;
    end
    check_eq("mis_no_req", 32'(rc), 32'd0);
    check_eq("mis_rdm_hold", read_data_m, 32'hFFFF_80FF);
    mem_read_m = 1'b0;
    #1;
    check_eq("mis_clear", 32'(addr_err_m), 32'd0);
    step();

    // Timeout with no ack
    run_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, 0, rc, dc, we, be, a, wdat, berr);
    check_eq("to_req_cycles", 32'(rc), 32'd4);
    check_eq("to_done_cyc", 32'(dc), 32'd5);
    check_eq("to_berr", 32'(berr), 32'd1);
    check_eq("to_rdm_zero", read_data_m, 32'd0);
    check_eq("to_berr_pulse", 32'(bus_err_m), 32'd0);

    // Ack in the final timeout cycle wins
    run_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h1122_3344, 4, rc, dc, we, be, a, wdat, berr);
    check_eq("late_req_cycles", 32'(rc), 32'd4);
    check_eq("late_done_cyc", 32'(dc), 32'd5);
    check_eq("late_berr", 32'(berr), 32'd0);
    check_eq("late_rdm", read_data_m, 32'h1122_3344);

    // Reset in BUSY cycle 2
    mem_read_m = 1'b1;
    mem_size_m = 2'b10;
    alu_out_m  = 32'h200;
    step();
    check_eq("rb_req_c1", 32'(dmem_req), 32'd1);
    step();
    rst_n      = 1'b0;
    mem_read_m = 1'b0;
    #1;
    check_eq("rb_req", 32'(dmem_req), 32'd0);
    check_eq("rb_addr", dmem_addr, 32'd0);
    check_eq("rb_be", 32'(dmem_be), 32'd0);
    check_eq("rb_rdm", read_data_m, 32'd0);
    check_eq("rb_stall", 32'(stall_m), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    run_op(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'hCAFE_F00D, 1, rc, dc, we, be, a, wdat, berr);
    check_eq("post_rst_done", 32'(dc), 32'd2);
    check_eq("post_rst_rdm", read_data_m, 32'hCAFE_F00D);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit of the MIPS32 pipeline: takes the effective address and store data from the EX/MEM registers, runs a req/ack transaction on the data-memory port, and produces the aligned, sign-/zero-extended load result that the MEM/WB registers capture as read_data_m. It asserts stall_m until the transaction completes, checks alignment, and aborts transactions that never acknowledge.

## Interface
- TIMEOUT, 255: maximum cycles in BUSY without dmem_ack before abort; ≥1
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mem_read_m  in  1  load in MEM stage
- mem_write_m  in  1  store in MEM stage; has priority if both asserted
- mem_size_m  in  2  00 byte, 01 half, 10 word; 11 treated as word
- mem_unsigned_m  in  1  1 = zero-extend load (LBU/LHU), 0 = sign-extend
- alu_out_m  in  32  effective byte address
- write_data_m  in  32  store data, right-justified
- dmem_req  out  1  request, registered, held until ack or abort
- dmem_we  out  1  1 = write transaction
- dmem_addr  out  32  {alu_out_m[31:2],2'b00}, latched at issue
- dmem_be  out  4  byte enables, latched at issue
- dmem_wdata  out  32  lane-replicated store data, latched at issue
- dmem_rdata  in  32  read data, valid when dmem_ack=1
- dmem_ack  in  1  one-cycle completion strobe
- read_data_m  out  32  registered formatted load result
- stall_m  out  1  combinational; freezes PC/IF/ID/EX and EX/MEM registers
- addr_err_m  out  1  combinational misalignment flag
- bus_err_m  out  1  registered one-cycle abort pulse

## Operation
- op = mem_read_m | mem_write_m; misaligned = op & ((size=half & addr[0]) | (size=word & addr[1:0]≠0)).
- FSM states IDLE, BUSY, DONE.
- IDLE: op & !misaligned → BUSY; on that edge dmem_req←1, dmem_we←mem_write_m, addr/be/wdata latched, timeout counter←0. misaligned → stay IDLE, no request, addr_err_m=1.
- BUSY: dmem_ack=1 → DONE, dmem_req←0, if load read_data_m←formatted dmem_rdata. No ack and counter=TIMEOUT-1 → DONE, dmem_req←0, bus_err_m←1, read_data_m←0 if load. Otherwise counter+1. Ack in final timeout cycle wins (no error).
- DONE: one cycle, stall_m=0, then IDLE unconditionally (next op is a new instruction).
- stall_m = (state=IDLE & op & !misaligned) | state=BUSY.
- Store lanes: byte be=0001<<addr[1:0], wdata={4{wd[7:0]}}; half be=addr[1]?1100:0011, wdata={2{wd[15:0]}}; word be=1111, wdata=wd.
- Load format: byte lane = rdata[8*addr[1:0]+:8], half = addr[1]?rdata[31:16]:rdata[15:0], extended per mem_unsigned_m; word unchanged.
- read_data_m changes only on load completion/abort; holds across stores and idle cycles.
- Reset values: state IDLE, dmem_req 0, dmem_we 0, dmem_addr 0, dmem_be 0, dmem_wdata 0, read_data_m 0, bus_err_m 0, counter 0.

## Timing
- Cycle 0 (IDLE, op present): stall_m=1. Cycle 1: dmem_req=1. Ack in cycle k≥1 → DONE in cycle k+1, stall_m=0, read_data_m valid; MEM/WB captures at end of cycle k+1.
- Minimum MEM occupancy 3 cycles (ack in cycle 1); maximum TIMEOUT+2.
- bus_err_m high exactly in the DONE cycle of an aborted access.
- dmem_addr/be/wdata/we stable for whole of dmem_req high; dmem_ack outside BUSY ignored.
- Inputs must be stable while stall_m=1 (EX/MEM frozen); changes are ignored after issue.
- Reset mid-BUSY: dmem_req drops asynchronously; memory must tolerate abandoned request.

## Test plan
- SW, addr 0x0000_0104, wd 0xDEADBEEF, ack after 2 cycles → dmem_req cycles 1–2, be 1111, addr 0x104, stall_m high cycles 0–2, low cycle 3.
- LB addr 0x203, rdata 0x80FF_0000, signed → read_data_m 0xFFFF_FF80; LBU same → 0x0000_0080; LH addr 0x202 signed → 0xFFFF_80FF.
- SB addr 0x11, wd 0x0000_00AB → be 0010, wdata 0xABABABAB; SH addr 0x12, wd 0x1234 → be 1100, wdata 0x12341234.
- LW addr 0x102 → addr_err_m=1, stall_m=0, dmem_req never asserted, read_data_m unchanged.
- TIMEOUT=4, no ack → dmem_req high 4 cycles, bus_err_m pulse in DONE, read_data_m 0; variant with ack in 4th cycle → no error, data captured.
- rst_n low in BUSY cycle 2 → dmem_req 0 immediately, all outputs at reset values; next LW completes normally.
